mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Parametrised N-master to 1-slave memory bus arbiter with fixed-priority or round-robin modes.
//  Replaces the separate instruction and data buses at the core boundary with one shared memory port.
//  Masters are prefetch, load/store, and later DMA/debug ports.
//  Supports bus locking for LOCK-prefixed read-modify-write sequences.
// PARAMETERS
//  NUM_MASTERS  2   number of requesting masters, 1..8; master 0 is highest fixed priority
//  ADDR_WIDTH   19  word address width, carried as bits [ADDR_WIDTH:1]
//  DATA_WIDTH   16  data width; bytesel width = DATA_WIDTH/8
//  ROUND_ROBIN  0   0 = fixed priority (lowest index wins), 1 = round-robin after last grant
// PORTS
//  clk            in   1                 clock
//  reset          in   1                 asynchronous, active-high reset
//  m_access       in   N                 per-master request, held until its m_ack
//  m_wr_en        in   N                 per-master write strobe
//  m_lock         in   N                 per-master lock: keep the bus across consecutive transfers
//  m_addr         in   N*ADDR_WIDTH      packed per-master addresses, master i at [i*AW +: AW]
//  m_data_out     in   N*DATA_WIDTH      packed per-master write data
//  m_bytesel      in   N*DATA_WIDTH/8    packed per-master byte selects
//  m_ack          out  N                 one-hot, single-cycle completion pulse to the granted master
//  m_data_in      out  DATA_WIDTH        read data, shared by all masters; valid with m_ack
//  s_access       out  1                 slave request
//  s_wr_en        out  1                 slave write strobe
//  s_addr         out  ADDR_WIDTH        slave word address
//  s_data_out     out  DATA_WIDTH        slave write data
//  s_bytesel      out  DATA_WIDTH/8      slave byte selects
//  s_ack          in   1                 slave completion
//  s_data_in      in   DATA_WIDTH        slave read data
//  grant          out  log2(N) (min 1)   index of the current or last granted master (debug/trace)
// BEHAVIOUR
//  Reset (async):
//   - s_access=0, m_ack=0, grant=0, s_addr/s_data_out/s_bytesel/s_wr_en=0.
//   - RR pointer set so master 0 wins first. State=IDLE, lock_held=0.
//  FSM, IDLE:
//   - If any m_access, select a winner, latch its addr/data/bytesel/wr_en into the s_* registers.
//   - Set grant, s_access=1 and go BUSY.
//  FSM, BUSY:
//   - s_* outputs are held stable until s_ack.
//   - On s_ack: s_access=0 that edge, m_ack[grant]=1 for exactly 1 cycle, then go IDLE.
//  Latency and throughput:
//   - Request to s_access: 1 cycle. s_ack to m_ack: 1 cycle (registered).
//   - m_data_in = s_data_in captured on s_ack, valid only while m_ack is high.
//   - Minimum request spacing per transfer is 3 cycles (IDLE, BUSY, ack).
//  Winner selection:
//   - Fixed priority: lowest set index.
//   - Round robin: first set index searching upward from (last_grant+1) mod N.
//  Lock:
//   - lock_held is set on grant if m_lock[grant]=1, and is sampled again at each grant.
//   - While lock_held, only the locked master may win in IDLE.
//   - Other requests wait even when the locked master is idle; lock_held clears when that master's m_lock=0 in IDLE.
//  Request withdrawn mid-transfer (master drops m_access in BUSY):
//   - This is illegal protocol.
//   - The arbiter still completes the slave cycle and still pulses m_ack; no abort.
//  Simultaneous events:
//   - A new request arriving on the s_ack cycle is arbitrated in the following IDLE cycle.
//   - Requests in the same cycle are resolved purely by the selected mode.
//  N=1: the arbiter degenerates to a 1-cycle registered pass-through; grant is constant 0.
//  Reset mid-BUSY: the transfer is abandoned and s_access drops immediately; no m_ack is issued.
// TESTING
//  1. N=2 fixed priority: m_access=2'b11 held, slave acks after 2 cycles
//     -> grants 0,0,0... and master 1 starves while master 0 keeps requesting.
//  2. N=4 ROUND_ROBIN=1: all four request continuously -> grant sequence 0,1,2,3,0; every m_ack is one-hot, one cycle.
//  3. Master 1 read at addr 19'h1234, slave returns 16'hBEEF after 3 wait cycles
//     -> s_addr=19'h1234, s_wr_en=0; m_data_in=16'hBEEF with m_ack=2'b10.
//  4. Master 1 holds m_lock=1 for 2 transfers while master 0 requests
//     -> master 0 is not granted until master 1 is IDLE with m_lock=0.
//  5. Byte write from master 0: bytesel=2'b10, data=16'hAB00 -> s_bytesel=2'b10, s_data_out stable until s_ack.
//  6. Assert reset during BUSY -> s_access=0 asynchronously, m_ack stays 0; a fresh request after reset is granted to master 0.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Brief    : N-master to 1-slave memory bus arbiter, fixed-priority or
//            round-robin selection, with bus locking for RMW sequences.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 19,
    parameter int DATA_WIDTH  = 16,
    parameter bit ROUND_ROBIN = 1'b0,
    localparam int c_grant_w  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
    localparam int c_be_w     = DATA_WIDTH / 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_MASTERS-1:0]            m_access,
    input  logic [NUM_MASTERS-1:0]            m_wr_en,
    input  logic [NUM_MASTERS-1:0]            m_lock,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data_out,
    input  logic [NUM_MASTERS*c_be_w-1:0]     m_bytesel,
    output logic [NUM_MASTERS-1:0]            m_ack,
    output logic [DATA_WIDTH-1:0]             m_data_in,
    output logic                              s_access,
    output logic                              s_wr_en,
    output logic [ADDR_WIDTH-1:0]             s_addr,
    output logic [DATA_WIDTH-1:0]             s_data_out,
    output logic [c_be_w-1:0]                 s_bytesel,
    input  logic                              s_ack,
    input  logic [DATA_WIDTH-1:0]             s_data_in,
    output logic [c_grant_w-1:0]              grant
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t                  r_state;
    logic                    r_s_access;
    logic                    r_s_wr_en;
    logic [ADDR_WIDTH-1:0]   r_s_addr;
    logic [DATA_WIDTH-1:0]   r_s_data_out;
    logic [c_be_w-1:0]       r_s_bytesel;
    logic [NUM_MASTERS-1:0]  r_m_ack;
    logic [DATA_WIDTH-1:0]   r_m_data_in;
    logic [c_grant_w-1:0]    r_grant;
    logic [c_grant_w-1:0]    r_rr_base;
    logic                    r_lock_held;

    logic                    w_locked;
    logic [NUM_MASTERS-1:0]  w_grant_onehot;
    logic [NUM_MASTERS-1:0]  w_cand;
    logic [c_grant_w-1:0]    w_winner;
    logic [c_grant_w-1:0]    w_next_base;

    // A held lock only survives while its owner keeps m_lock asserted.
    assign w_locked       = r_lock_held & m_lock[r_grant];
    assign w_grant_onehot = NUM_MASTERS'(1) << r_grant;
    assign w_cand         = w_locked ? (m_access & w_grant_onehot) : m_access;

    generate
        if (NUM_MASTERS == 1) begin : g_single
            assign w_winner    = '0;
            assign w_next_base = '0;
        end else begin : g_multi
            int                   w_base;
            logic [c_grant_w-1:0] w_idx;

            assign w_base = ROUND_ROBIN ? int'(r_rr_base) : 0;

            // Scan downward so the lowest offset from the base wins last.
            always_comb begin
                w_winner = '0;
                w_idx    = '0;
                for (int off = NUM_MASTERS - 1; off >= 0; off--) begin
                    w_idx = c_grant_w'((w_base + off) % NUM_MASTERS);
                    if (w_cand[w_idx]) begin
                        w_winner = w_idx;
                    end
                end
            end

            assign w_next_base = (int'(w_winner) == NUM_MASTERS - 1) ? '0
                                                                     : w_winner + 1'b1;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_s_access   <= 1'b0;
            r_s_wr_en    <= 1'b0;
            r_s_addr     <= '0;
            r_s_data_out <= '0;
            r_s_bytesel  <= '0;
            r_m_ack      <= '0;
            r_m_data_in  <= '0;
            r_grant      <= '0;
            r_rr_base    <= '0;
            r_lock_held  <= 1'b0;
        end else begin
            r_m_ack <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (|w_cand) begin
                        r_grant      <= w_winner;
                        r_rr_base    <= w_next_base;
                        r_lock_held  <= m_lock[w_winner];
                        r_s_wr_en    <= m_wr_en[w_winner];
                        r_s_addr     <= m_addr[int'(w_winner)*ADDR_WIDTH +: ADDR_WIDTH];
                        r_s_data_out <= m_data_out[int'(w_winner)*DATA_WIDTH +: DATA_WIDTH];
                        r_s_bytesel  <= m_bytesel[int'(w_winner)*c_be_w +: c_be_w];
                        r_s_access   <= 1'b1;
                        r_state      <= ST_BUSY;
                    end else begin
                        r_lock_held  <= w_locked;
                    end
                end
                ST_BUSY: begin
                    // Completes even if the master withdrew its request.
                    if (s_ack) begin
                        r_s_access  <= 1'b0;
                        r_m_ack     <= w_grant_onehot;
                        r_m_data_in <= s_data_in;
                        r_state     <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    // Requests seen alongside m_ack are stale; arbitrate next cycle.
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_ack      = r_m_ack;
    assign m_data_in  = r_m_data_in;
    assign s_access   = r_s_access;
    assign s_wr_en    = r_s_wr_en;
    assign s_addr     = r_s_addr;
    assign s_data_out = r_s_data_out;
    assign s_bytesel  = r_s_bytesel;
    assign grant      = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Brief    : Directed bench for mem_bus_arbiter (N=2 fixed, N=4 round-robin).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    // N=2 fixed-priority instance
    logic [1:0]  a_m_access, a_m_wr_en, a_m_lock, a_m_ack;
    logic [37:0] a_m_addr;
    logic [31:0] a_m_data_out;
    logic [3:0]  a_m_bytesel;
    logic [15:0] a_m_data_in, a_s_data_out, a_s_data_in;
    logic        a_s_access, a_s_wr_en, a_s_ack;
    logic [18:0] a_s_addr;
    logic [1:0]  a_s_bytesel;
    logic [0:0]  a_grant;

    // N=4 round-robin instance
    logic [3:0]  b_m_access, b_m_wr_en, b_m_lock, b_m_ack;
    logic [75:0] b_m_addr;
    logic [63:0] b_m_data_out;
    logic [7:0]  b_m_bytesel;
    logic [15:0] b_m_data_in, b_s_data_out, b_s_data_in;
    logic        b_s_access, b_s_wr_en, b_s_ack;
    logic [18:0] b_s_addr;
    logic [1:0]  b_s_bytesel;
    logic [1:0]  b_grant;

    mem_bus_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(19), .DATA_WIDTH(16), .ROUND_ROBIN(1'b0)) dut (
        .clk(clk), .reset(reset),
        .m_access(a_m_access), .m_wr_en(a_m_wr_en), .m_lock(a_m_lock),
        .m_addr(a_m_addr), .m_data_out(a_m_data_out), .m_bytesel(a_m_bytesel),
        .m_ack(a_m_ack), .m_data_in(a_m_data_in),
        .s_access(a_s_access), .s_wr_en(a_s_wr_en), .s_addr(a_s_addr),
        .s_data_out(a_s_data_out), .s_bytesel(a_s_bytesel),
        .s_ack(a_s_ack), .s_data_in(a_s_data_in), .grant(a_grant)
    );

    mem_bus_arbiter #(.NUM_MASTERS(4), .ADDR_WIDTH(19), .DATA_WIDTH(16), .ROUND_ROBIN(1'b1)) dut_rr (
        .clk(clk), .reset(reset),
        .m_access(b_m_access), .m_wr_en(b_m_wr_en), .m_lock(b_m_lock),
        .m_addr(b_m_addr), .m_data_out(b_m_data_out), .m_bytesel(b_m_bytesel),
        .m_ack(b_m_ack), .m_data_in(b_m_data_in),
        .s_access(b_s_access), .s_wr_en(b_s_wr_en), .s_addr(b_s_addr),
        .s_data_out(b_s_data_out), .s_bytesel(b_s_bytesel),
        .s_ack(b_s_ack), .s_data_in(b_s_data_in), .grant(b_grant)
    );

    // Stimulus helpers: wait (bounded) for a slave request, then answer it.
    task automatic a_wait_access(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (a_s_access) ok = 1'b1;
        end
    endtask

    task automatic b_wait_access(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (b_s_access) ok = 1'b1;
        end
    endtask

    task automatic a_slave_ack(input int waitc, input logic [15:0] d);
        repeat (waitc) @(negedge clk);
        a_s_ack = 1'b1; a_s_data_in = d;
        @(negedge clk);
        a_s_ack = 1'b0; a_s_data_in = '0;
    endtask

    task automatic b_slave_ack(input int waitc, input logic [15:0] d);
        repeat (waitc) @(negedge clk);
        b_s_ack = 1'b1; b_s_data_in = d;
        @(negedge clk);
        b_s_ack = 1'b0; b_s_data_in = '0;
    endtask

    task automatic settle();
        a_m_access = '0; b_m_access = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({a_s_access, a_m_ack, a_grant, a_s_wr_en} !== 5'b0 || a_s_addr !== '0 ||
            a_s_data_out !== '0 || a_s_bytesel !== '0) begin
            tests_failed++;
            $display("FAIL reset_a: access=%b ack=%b grant=%b wr=%b addr=%h data=%h be=%b required all 0",
                     a_s_access, a_m_ack, a_grant, a_s_wr_en, a_s_addr, a_s_data_out, a_s_bytesel);
        end
        tests_run++;
        if ({b_s_access, b_m_ack, b_grant} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_b: access=%b ack=%b grant=%b required 0", b_s_access, b_m_ack, b_grant);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fixed_priority();
        bit ok;
        a_m_access = 2'b11;
        for (int k = 0; k < 3; k++) begin
            a_wait_access(ok);
            tests_run++;
            if (!ok || a_grant !== 1'b0) begin
                tests_failed++;
                $display("FAIL fp_grant[%0d]: ok=%0d grant=%0d required 0", k, ok, a_grant);
            end
            a_slave_ack(2, 16'h0100 + 16'(k));
            tests_run++;
            if (a_m_ack !== 2'b01) begin
                tests_failed++;
                $display("FAIL fp_ack[%0d]: m_ack=%b required 01", k, a_m_ack);
            end
        end
        a_m_access = 2'b10;
        a_wait_access(ok);
        tests_run++;
        if (!ok || a_grant !== 1'b1) begin
            tests_failed++;
            $display("FAIL fp_m1_grant: ok=%0d grant=%0d required 1", ok, a_grant);
        end
        a_slave_ack(2, 16'h0200);
        tests_run++;
        if (a_m_ack !== 2'b10) begin
            tests_failed++;
            $display("FAIL fp_m1_ack: m_ack=%b required 10", a_m_ack);
        end
        settle();
    endtask

    task automatic test_read();
        bit ok;
        a_m_addr   = {19'h1234, 19'h00000};
        a_m_wr_en  = 2'b00;
        a_m_access = 2'b10;
        a_wait_access(ok);
        tests_run++;
        if (!ok || a_s_addr !== 19'h1234 || a_s_wr_en !== 1'b0 || a_grant !== 1'b1) begin
            tests_failed++;
            $display("FAIL rd_req: ok=%0d addr=%h wr=%b grant=%0d required addr=01234 wr=0 grant=1",
                     ok, a_s_addr, a_s_wr_en, a_grant);
        end
        a_slave_ack(3, 16'hBEEF);
        tests_run++;
        if (a_m_ack !== 2'b10 || a_m_data_in !== 16'hBEEF || a_s_access !== 1'b0) begin
            tests_failed++;
            $display("FAIL rd_ack: m_ack=%b data=%h s_access=%b required 10 BEEF 0",
                     a_m_ack, a_m_data_in, a_s_access);
        end
        a_m_access = 2'b00;
        @(negedge clk);
        tests_run++;
        if (a_m_ack !== 2'b00) begin
            tests_failed++;
            $display("FAIL rd_ack_pulse: m_ack=%b required 00", a_m_ack);
        end
        settle();
    endtask

    task automatic test_byte_write();
        bit ok;
        a_m_addr     = {19'h0, 19'h00055};
        a_m_data_out = {16'h0, 16'hAB00};
        a_m_bytesel  = 4'b0010;
        a_m_wr_en    = 2'b01;
        a_m_access   = 2'b01;
        a_wait_access(ok);
        tests_run++;
        if (!ok || a_s_bytesel !== 2'b10 || a_s_data_out !== 16'hAB00 || a_s_wr_en !== 1'b1 ||
            a_s_addr !== 19'h00055) begin
            tests_failed++;
            $display("FAIL wr_req: ok=%0d be=%b data=%h wr=%b addr=%h required 10 AB00 1 00055",
                     ok, a_s_bytesel, a_s_data_out, a_s_wr_en, a_s_addr);
        end
        a_m_data_out = 32'h0000_FFFF;
        a_m_bytesel  = 4'b0011;
        repeat (2) @(negedge clk);
        tests_run++;
        if (a_s_data_out !== 16'hAB00 || a_s_bytesel !== 2'b10 || a_s_access !== 1'b1) begin
            tests_failed++;
            $display("FAIL wr_stable: data=%h be=%b access=%b required AB00 10 1",
                     a_s_data_out, a_s_bytesel, a_s_access);
        end
        a_slave_ack(0, 16'h0);
        tests_run++;
        if (a_m_ack !== 2'b01) begin
            tests_failed++;
            $display("FAIL wr_ack: m_ack=%b required 01", a_m_ack);
        end
        a_m_wr_en = 2'b00;
        settle();
    endtask

    task automatic test_lock();
        bit ok;
        a_m_lock   = 2'b10;
        a_m_access = 2'b10;
        a_wait_access(ok);
        tests_run++;
        if (!ok || a_grant !== 1'b1) begin
            tests_failed++;
            $display("FAIL lk_first: ok=%0d grant=%0d required 1", ok, a_grant);
        end
        a_m_access = 2'b11;
        a_slave_ack(1, 16'h0);
        tests_run++;
        if (a_m_ack !== 2'b10) begin
            tests_failed++;
            $display("FAIL lk_ack1: m_ack=%b required 10", a_m_ack);
        end
        a_wait_access(ok);
        tests_run++;
        if (!ok || a_grant !== 1'b1) begin
            tests_failed++;
            $display("FAIL lk_second: ok=%0d grant=%0d required 1", ok, a_grant);
        end
        a_slave_ack(1, 16'h0);
        tests_run++;
        if (a_m_ack !== 2'b10) begin
            tests_failed++;
            $display("FAIL lk_ack2: m_ack=%b required 10", a_m_ack);
        end
        a_m_access = 2'b01;
        repeat (3) @(negedge clk);
        tests_run++;
        if (a_s_access !== 1'b0 || a_grant !== 1'b1) begin
            tests_failed++;
            $display("FAIL lk_hold: s_access=%b grant=%0d required 0 1", a_s_access, a_grant);
        end
        a_m_lock = 2'b00;
        a_wait_access(ok);
        tests_run++;
        if (!ok || a_grant !== 1'b0) begin
            tests_failed++;
            $display("FAIL lk_release: ok=%0d grant=%0d required 0", ok, a_grant);
        end
        a_slave_ack(0, 16'h0);
        tests_run++;
        if (a_m_ack !== 2'b01) begin
            tests_failed++;
            $display("FAIL lk_ack3: m_ack=%b required 01", a_m_ack);
        end
        settle();
    endtask

    task automatic test_round_robin();
        bit         ok;
        logic [1:0] exp_g;
        logic [3:0] exp_ack;
        b_m_access = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_g   = 2'(k % 4);
            exp_ack = 4'b0001 << exp_g;
            b_wait_access(ok);
            tests_run++;
            if (!ok || b_grant !== exp_g) begin
                tests_failed++;
                $display("FAIL rr_grant[%0d]: ok=%0d grant=%0d required %0d", k, ok, b_grant, exp_g);
            end
            b_slave_ack(1, 16'h0);
            tests_run++;
            if (b_m_ack !== exp_ack) begin
                tests_failed++;
                $display("FAIL rr_ack[%0d]: m_ack=%b required %b", k, b_m_ack, exp_ack);
            end
            @(negedge clk);
            tests_run++;
            if (b_m_ack !== 4'b0000) begin
                tests_failed++;
                $display("FAIL rr_pulse[%0d]: m_ack=%b required 0000", k, b_m_ack);
            end
        end
        settle();
    endtask

    task automatic test_reset_mid_busy();
        bit ok;
        a_m_access = 2'b01;
        a_wait_access(ok);
        #2 reset = 1'b1;
        #1;
        tests_run++;
        if (!ok || a_s_access !== 1'b0 || a_m_ack !== 2'b00) begin
            tests_failed++;
            $display("FAIL rst_busy_async: ok=%0d s_access=%b m_ack=%b required 0 00",
                     ok, a_s_access, a_m_ack);
        end
        @(negedge clk);
        a_s_ack = 1'b1;
        @(negedge clk);
        tests_run++;
        if (a_m_ack !== 2'b00 || a_s_access !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_busy_noack: m_ack=%b s_access=%b required 00 0", a_m_ack, a_s_access);
        end
        a_s_ack    = 1'b0;
        reset      = 1'b0;
        a_m_access = 2'b11;
        a_wait_access(ok);
        tests_run++;
        if (!ok || a_grant !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_fresh_grant: ok=%0d grant=%0d required 0", ok, a_grant);
        end
        a_slave_ack(1, 16'h5A5A);
        tests_run++;
        if (a_m_ack !== 2'b01 || a_m_data_in !== 16'h5A5A) begin
            tests_failed++;
            $display("FAIL rst_fresh_ack: m_ack=%b data=%h required 01 5A5A", a_m_ack, a_m_data_in);
        end
        settle();
    endtask

    initial begin
        reset = 1'b1;
        a_m_access = '0; a_m_wr_en = '0; a_m_lock = '0; a_m_addr = '0;
        a_m_data_out = '0; a_m_bytesel = '0; a_s_ack = 1'b0; a_s_data_in = '0;
        b_m_access = '0; b_m_wr_en = '0; b_m_lock = '0; b_m_addr = '0;
        b_m_data_out = '0; b_m_bytesel = '0; b_s_ack = 1'b0; b_s_data_in = '0;
        test_reset();
        test_fixed_priority();
        test_read();
        test_byte_write();
        test_lock();
        test_round_robin();
        test_reset_mid_busy();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
